// File: rtl/gpio_controller_param.sv
// rtl/gpio_controller_param.sv - parametrised GPIO controller on the IO command bus
// Optional edge interrupt: define GPIO_EDGE_IRQ_EN.
module gpio_controller_param #(
    parameter int PIN_COUNT      = 8,
    parameter int PULSE_WIDTH    = 8,
    parameter int PULSE_PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 async_rst,
    input  logic                 clk_en,
    output logic                 IO_ACK,
    input  logic                 IO_REQ,
    input  logic                 IO_CommandEn,
    input  logic                 IO_ResponseRequested,
    output logic                 IO_CommandResponse,
    output logic                 IO_RegResponseFlag,
    output logic                 IO_MemResponseFlag,
    input  logic [3:0]           IO_DestRegIn,
    output logic [3:0]           IO_DestRegOut,
    input  logic [15:0]          IO_DataIn,
    output logic [15:0]          IO_DataOut,
    input  logic [PIN_COUNT-1:0] GPIO_DIn,
    output logic [PIN_COUNT-1:0] GPIO_DOut,
    output logic [PIN_COUNT-1:0] GPIO_DOutEn,
    output logic                 GPIO_IRQ
);

    localparam int PS_W = (PULSE_PRESCALE > 1) ? $clog2(PULSE_PRESCALE) : 1;
    typedef logic [PULSE_WIDTH-1:0] cnt_t;

    localparam logic [3:0] OP_WRBIT   = 4'd0;
    localparam logic [3:0] OP_WRWORD  = 4'd1;
    localparam logic [3:0] OP_TOGGLE  = 4'd2;
    localparam logic [3:0] OP_DIRBIT  = 4'd3;
    localparam logic [3:0] OP_DIRWORD = 4'd4;
    localparam logic [3:0] OP_RDOBIT  = 4'd5;
    localparam logic [3:0] OP_RDPBIT  = 4'd6;
    localparam logic [3:0] OP_RDOWORD = 4'd7;
    localparam logic [3:0] OP_RDPWORD = 4'd8;
    localparam logic [3:0] OP_RDEDGE  = 4'd9;
    localparam logic [3:0] OP_PULSE   = 4'd10;
    localparam logic [3:0] OP_RDBUSY  = 4'd11;

    logic [PIN_COUNT-1:0] r_out, r_oe, r_base;
    logic [PIN_COUNT-1:0] r_s1, r_s2, r_s3;
    logic [PIN_COUNT-1:0] r_rise, r_fall;
    cnt_t                 r_cnt [PIN_COUNT];
    logic [PS_W-1:0]      r_ps;
    logic                 r_cmd_resp, r_reg_resp;
    logic [3:0]           r_dest;
    logic [15:0]          r_data;

    logic [3:0]           w_op;
    logic [2:0]           w_addr;
    logic [7:0]           w_d;
    cnt_t                 w_len;
    logic                 w_accept, w_act, w_clr, w_tick, w_isread;
    logic [15:0]          w_rd;
    logic [PIN_COUNT-1:0] w_busy, w_rise, w_fall;
    logic [PIN_COUNT-1:0] w_out_n, w_oe_n, w_base_n;
    cnt_t                 w_cnt_n [PIN_COUNT];
    logic                 w_bit_out, w_bit_pin;
    logic                 w_unused;

    assign w_op     = IO_DataIn[15:12];
    assign w_addr   = IO_DataIn[10:8];
    assign w_d      = IO_DataIn[7:0];
    assign w_len    = w_d[PULSE_WIDTH-1:0];
    assign w_unused = IO_DataIn[11];

    assign w_accept = IO_REQ && clk_en && (IO_CommandEn || IO_ResponseRequested);
    assign w_act    = w_accept && IO_CommandEn;
    assign w_clr    = w_accept && (w_op == OP_RDEDGE);
    assign w_tick   = (r_ps == PS_W'(PULSE_PRESCALE - 1));
    assign w_rise   = r_s2 & ~r_s3;
    assign w_fall   = ~r_s2 & r_s3;

    always_comb begin
        for (int i = 0; i < PIN_COUNT; i++) w_busy[i] = (r_cnt[i] != '0);
    end

    always_comb begin
        w_bit_out = 1'b0;
        w_bit_pin = 1'b0;
        for (int i = 0; i < PIN_COUNT; i++) begin
            if (w_addr == 3'(i)) begin
                w_bit_out = r_out[i];
                w_bit_pin = r_s2[i];
            end
        end
        w_rd     = 16'h0000;
        w_isread = 1'b1;
        case (w_op)
            OP_RDOBIT:  w_rd = {15'b0, w_bit_out};
            OP_RDPBIT:  w_rd = {15'b0, w_bit_pin};
            OP_RDOWORD: w_rd = 16'(r_out);
            OP_RDPWORD: w_rd = 16'(r_s2);
            OP_RDEDGE:  w_rd = {8'(r_fall), 8'(r_rise)};
            OP_RDBUSY:  w_rd = 16'(w_busy);
            default:    w_isread = 1'b0;
        endcase
    end

    // Timer expiry is evaluated first so that a command in the same cycle overrides it.
    always_comb begin
        w_out_n  = r_out;
        w_oe_n   = r_oe;
        w_base_n = r_base;
        w_cnt_n  = r_cnt;
        for (int i = 0; i < PIN_COUNT; i++) begin
            if (w_tick && w_busy[i]) begin
                w_cnt_n[i] = r_cnt[i] - cnt_t'(1);
                if (r_cnt[i] == cnt_t'(1)) w_out_n[i] = r_base[i];
            end
        end
        if (w_act) begin
            for (int i = 0; i < PIN_COUNT; i++) begin
                if (w_addr == 3'(i)) begin
                    case (w_op)
                        OP_WRBIT: begin
                            w_out_n[i] = w_d[0];
                            w_cnt_n[i] = '0;
                        end
                        OP_TOGGLE: begin
                            w_out_n[i] = ~r_out[i];
                            w_cnt_n[i] = '0;
                        end
                        OP_DIRBIT: w_oe_n[i] = w_d[0];
                        OP_PULSE: begin
                            if (w_len != '0) begin
                                w_cnt_n[i] = w_len;
                                if (w_busy[i]) begin
                                    w_out_n[i] = r_out[i];
                                end else begin
                                    w_base_n[i] = r_out[i];
                                    w_out_n[i]  = ~r_out[i];
                                end
                            end else if (w_busy[i]) begin
                                w_out_n[i] = r_base[i];
                                w_cnt_n[i] = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            if (w_op == OP_WRWORD) begin
                w_out_n = w_d[PIN_COUNT-1:0];
                for (int i = 0; i < PIN_COUNT; i++) w_cnt_n[i] = '0;
            end
            if (w_op == OP_DIRWORD) w_oe_n = w_d[PIN_COUNT-1:0];
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_out      <= '0;
            r_oe       <= '0;
            r_base     <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_ps       <= '0;
            r_cmd_resp <= 1'b0;
            r_reg_resp <= 1'b0;
            r_dest     <= 4'h0;
            r_data     <= 16'h0000;
            for (int i = 0; i < PIN_COUNT; i++) r_cnt[i] <= '0;
        end else if (clk_en) begin
            r_out  <= w_out_n;
            r_oe   <= w_oe_n;
            r_base <= w_base_n;
            r_cnt  <= w_cnt_n;
            r_s1   <= GPIO_DIn;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_ps   <= w_tick ? '0 : r_ps + PS_W'(1);
            // A fresh edge in the clearing cycle survives the clear.
            r_rise <= (w_clr ? '0 : r_rise) | w_rise;
            r_fall <= (w_clr ? '0 : r_fall) | w_fall;
            if (w_accept) begin
                r_cmd_resp <= IO_CommandEn;
                r_reg_resp <= IO_ResponseRequested && w_isread;
                r_dest     <= IO_DestRegIn;
                r_data     <= w_rd;
            end else begin
                r_cmd_resp <= 1'b0;
                r_reg_resp <= 1'b0;
            end
        end
    end

`ifdef GPIO_EDGE_IRQ_EN
    logic [PIN_COUNT-1:0] r_mask;
    logic                 r_irq;
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else if (clk_en) begin
            if (w_act && w_op == 4'd12) r_mask <= w_d[PIN_COUNT-1:0];
            r_irq <= |((r_rise | r_fall) & r_mask);
        end
    end
    assign GPIO_IRQ = r_irq;
`else
    assign GPIO_IRQ = 1'b0;
`endif

    assign IO_ACK             = clk_en;
    assign IO_CommandResponse = r_cmd_resp;
    assign IO_RegResponseFlag = r_reg_resp;
    assign IO_MemResponseFlag = 1'b0;
    assign IO_DestRegOut      = r_dest;
    assign IO_DataOut         = r_data;
    assign GPIO_DOut          = r_out;
    assign GPIO_DOutEn        = r_oe;

endmodule
